compare_peak_tracker: RTL and testbench

- Streaming extremum detector for DSP sample frames; successor to the team's combinational greater-than comparator.
- Accepts one sample per valid/ready beat and tracks the running maximum (or minimum) and its index within the frame.
- Presents the frame result through an output valid/ready handshake.
- Sits after ADC/filter stages for peak detection and argmax selection.

---
 rtl/compare_peak_tracker.sv | 100 ++++++++++
 tb/tb_compare_peak_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/compare_peak_tracker.sv
// Streaming extremum detector: tracks the max (or min) sample of a frame and its
// beat index, then holds the frame result on a valid/ready output until taken.
module compare_peak_tracker #(
    parameter int WIDTH  = 16,
    parameter int IDX_W  = 10,
    parameter int SIGNED = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mode_min,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_peak,
    output logic [IDX_W-1:0] o_index,
    output logic [IDX_W-1:0] o_count,
    output logic             o_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    // Flipping the MSB maps two's complement onto an order-preserving unsigned key.
    localparam logic [WIDTH-1:0] KEY_FLIP = {(SIGNED != 0), {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic             mode_q;
    logic [WIDTH-1:0] peak_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cnt_q;
    logic             ovf_q;

    logic             accept;
    logic             cnt_sat;
    logic             better;
    logic [WIDTH-1:0] new_key;
    logic [WIDTH-1:0] peak_key;

    assign o_ready = (state != S_HOLD);
    assign o_valid = (state == S_HOLD);
    assign accept  = i_valid & o_ready;
    assign cnt_sat = (cnt_q == IDX_MAX);

    always_comb begin
        new_key  = i_data ^ KEY_FLIP;
        peak_key = peak_q ^ KEY_FLIP;
        // Strict compare so ties keep the earliest index.
        better   = mode_q ? (new_key < peak_key) : (new_key > peak_key);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            peak_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q <= i_mode_min;
                        peak_q <= i_data;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        state  <= i_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (cnt_sat) ovf_q <= 1'b1;
                        else         cnt_q <= cnt_q + 1'b1;
                        if (better) begin
                            peak_q <= i_data;
                            idx_q  <= cnt_sat ? IDX_MAX : cnt_q + 1'b1;
                        end
                        if (i_last) state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_peak  = peak_q;
    assign o_index = idx_q;
    assign o_count = cnt_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_compare_peak_tracker.sv
// Directed bench: 16-bit unsigned tracker plus signed/unsigned 8-bit trackers
// (IDX_W=3) sharing one stimulus bus.
module tb_compare_peak_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 16-bit unsigned, IDX_W=10
    logic        a_mode, a_valid, a_last, a_ready_in;
    logic [15:0] a_data;
    logic        a_ready, a_ovalid, a_ovf;
    logic [15:0] a_peak;
    logic [9:0]  a_index, a_count;

    // 8-bit, IDX_W=3, shared inputs
    logic        b_mode, b_valid, b_last, b_ready_in;
    logic [7:0]  b_data;
    logic        s_ready, s_ovalid, s_ovf, u_ready, u_ovalid, u_ovf;
    logic [7:0]  s_peak, u_peak;
    logic [2:0]  s_index, s_count, u_index, u_count;

    compare_peak_tracker #(.WIDTH(16), .IDX_W(10), .SIGNED(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode_min(a_mode), .i_valid(a_valid),
        .o_ready(a_ready), .i_data(a_data), .i_last(a_last), .o_valid(a_ovalid),
        .i_ready(a_ready_in), .o_peak(a_peak), .o_index(a_index), .o_count(a_count),
        .o_ovf(a_ovf)
    );

    compare_peak_tracker #(.WIDTH(8), .IDX_W(3), .SIGNED(1)) u_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode_min(b_mode), .i_valid(b_valid),
        .o_ready(s_ready), .i_data(b_data), .i_last(b_last), .o_valid(s_ovalid),
        .i_ready(b_ready_in), .o_peak(s_peak), .o_index(s_index), .o_count(s_count),
        .o_ovf(s_ovf)
    );

    compare_peak_tracker #(.WIDTH(8), .IDX_W(3), .SIGNED(0)) u_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode_min(b_mode), .i_valid(b_valid),
        .o_ready(u_ready), .i_data(b_data), .i_last(b_last), .o_valid(u_ovalid),
        .i_ready(b_ready_in), .o_peak(u_peak), .o_index(u_index), .o_count(u_count),
        .o_ovf(u_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on bus A; inputs change #1 after the edge, checks follow at the same point.
    task automatic a_cycle(input logic v, input logic [15:0] d, input logic l, input logic m);
        a_valid = v; a_data = d; a_last = l; a_mode = m;
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic b_cycle(input logic v, input logic [7:0] d, input logic l, input logic m);
        b_valid = v; b_data = d; b_last = l; b_mode = m;
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic a_release();
        a_ready_in = 1'b1;
        @(posedge clk); #1;
        a_ready_in = 1'b0;
        chk("a_release_valid", 32'(a_ovalid), 32'h0);
        chk("a_release_ready", 32'(a_ready), 32'h1);
    endtask

    task automatic b_release();
        b_ready_in = 1'b1;
        @(posedge clk); #1;
        b_ready_in = 1'b0;
        chk("b_release_valid", 32'({s_ovalid, u_ovalid}), 32'h0);
    endtask

    initial begin
        a_mode = 0; a_valid = 0; a_last = 0; a_data = '0; a_ready_in = 0;
        b_mode = 0; b_valid = 0; b_last = 0; b_data = '0; b_ready_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'({a_ready, s_ready, u_ready}), 32'h7);
        chk("rst_valid", 32'({a_ovalid, s_ovalid, u_ovalid}), 32'h0);
        chk("rst_peak", 32'(a_peak), 32'h0);
        chk("rst_idx_cnt_ovf", 32'({a_index, a_count, a_ovf}), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Max frame 5,9,3,9,1 - tie on 9 keeps index 1
        a_cycle(1, 16'd5, 0, 0);
        a_cycle(1, 16'd9, 0, 0);
        a_cycle(1, 16'd3, 0, 0);
        a_cycle(1, 16'd9, 0, 0);
        chk("max_valid_before_last", 32'(a_ovalid), 32'h0);
        a_cycle(1, 16'd1, 1, 0);
        chk("max_valid", 32'(a_ovalid), 32'h1);
        chk("max_peak", 32'(a_peak), 32'd9);
        chk("max_index", 32'(a_index), 32'd1);
        chk("max_count", 32'(a_count), 32'd4);
        chk("max_ovf", 32'(a_ovf), 32'h0);

        // Backpressure: offered beats during HOLD must be ignored
        for (int i = 0; i < 6; i++) begin
            a_cycle(1, 16'hFFFF, 1, 1);
            chk("bp_ready", 32'(a_ready), 32'h0);
            chk("bp_valid", 32'(a_ovalid), 32'h1);
            chk("bp_peak_idx", 32'({a_peak, 6'd0, a_index}), {16'd9, 6'd0, 10'd1});
        end
        a_release();

        // Mode latched as min on first beat; mid-frame toggles and gaps ignored
        a_ready_in = 1'b1;
        a_cycle(1, 16'd20, 0, 1);
        a_cycle(0, 16'd1, 1, 0);
        a_cycle(1, 16'd50, 0, 0);
        a_cycle(1, 16'd7, 0, 0);
        a_cycle(0, 16'd0, 1, 0);
        a_cycle(0, 16'd2, 0, 1);
        chk("gap_count", 32'(a_count), 32'd2);
        chk("gap_valid", 32'(a_ovalid), 32'h0);
        a_cycle(1, 16'd30, 1, 0);
        a_ready_in = 1'b0;
        chk("mode_valid", 32'(a_ovalid), 32'h1);
        chk("mode_peak", 32'(a_peak), 32'd7);
        chk("mode_index", 32'(a_index), 32'd2);
        chk("mode_count", 32'(a_count), 32'd3);
        a_release();

        // Single-beat frame
        a_cycle(1, 16'hABCD, 1, 0);
        chk("single_valid", 32'(a_ovalid), 32'h1);
        chk("single_fields", 32'({a_peak, 6'd0, a_index}), {16'hABCD, 16'd0});
        chk("single_count", 32'(a_count), 32'h0);
        a_release();

        // Reset after 3 beats discards the partial frame
        a_cycle(1, 16'd100, 0, 0);
        a_cycle(1, 16'd200, 0, 0);
        a_cycle(1, 16'd300, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(a_ready), 32'h1);
        chk("midrst_outs", 32'({a_ovalid, a_peak, a_index, a_count, a_ovf}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_cycle(1, 16'd4, 0, 0);
        a_cycle(1, 16'd2, 1, 0);
        chk("post_rst_valid", 32'(a_ovalid), 32'h1);
        chk("post_rst_peak", 32'(a_peak), 32'd4);
        chk("post_rst_index", 32'(a_index), 32'd0);
        chk("post_rst_count", 32'(a_count), 32'd1);

        // Reset during HOLD drops o_valid asynchronously
        rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", 32'(a_ovalid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Min frame 0x10,0x80,0x7F,0xFF: signed -> -128 @1, unsigned -> 0x10 @0
        b_cycle(1, 8'h10, 0, 1);
        b_cycle(1, 8'h80, 0, 0);
        b_cycle(1, 8'h7F, 0, 0);
        b_cycle(1, 8'hFF, 1, 0);
        chk("min_valid", 32'({s_ovalid, u_ovalid}), 32'h3);
        chk("min_s_peak", 32'(s_peak), 32'h80);
        chk("min_s_index", 32'(s_index), 32'd1);
        chk("min_u_peak", 32'(u_peak), 32'h10);
        chk("min_u_index", 32'(u_index), 32'd0);
        chk("min_count", 32'({s_count, u_count}), {26'd0, 3'd3, 3'd3});
        b_release();

        // Max frame 0x7F,0x80: signed keeps 0x7F, unsigned takes 0x80
        b_cycle(1, 8'h7F, 0, 0);
        b_cycle(1, 8'h80, 1, 0);
        chk("smax_s", 32'({s_peak, 5'd0, s_index}), {16'd0, 8'h7F, 8'h00});
        chk("smax_u", 32'({u_peak, 5'd0, u_index}), {16'd0, 8'h80, 8'h01});
        b_release();

        // Overflow: 10 beats, max 0x55 at beat 9
        for (int i = 0; i < 9; i++) b_cycle(1, 8'(i * 3), 0, 0);
        b_cycle(1, 8'h55, 1, 0);
        chk("ovf_valid", 32'(u_ovalid), 32'h1);
        chk("ovf_u_count", 32'(u_count), 32'd7);
        chk("ovf_u_index", 32'(u_index), 32'd7);
        chk("ovf_u_flag", 32'(u_ovf), 32'h1);
        chk("ovf_u_peak", 32'(u_peak), 32'h55);
        chk("ovf_s_all", 32'({s_peak, s_index, s_count, s_ovf}), {17'd0, 8'h55, 3'd7, 3'd7, 1'b1});
        b_release();

        b_cycle(1, 8'd3, 0, 0);
        b_cycle(1, 8'd1, 1, 0);
        chk("next_ovf_clear", 32'({s_ovf, u_ovf}), 32'h0);
        chk("next_u_fields", 32'({u_peak, u_index, u_count}), {18'd0, 8'd3, 3'd0, 3'd1});
        b_release();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
